sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_acc_pkg.sv | 17 +
 rtl/sum_accumulator_if.sv | 26 ++
 rtl/sum_acc_add.sv | 27 ++
 rtl/sum_accumulator.sv | 111 +++++++++++
 tb/tb_sum_accumulator.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_acc_pkg;

    // Block FSM: waiting for first beat, summing beats, presenting the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_BLOCK_LEN = 4;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / result-out handshake bundle for sum_accumulator.
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles the producer; out_ready throttles the result.
// Ports: master = producer/consumer side, slave = accumulator side.
interface sum_accumulator_if import sum_acc_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sum_acc_add.sv
// Accumulator adder with carry detect; optional clamp to all-ones on overflow.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_i/sample_i operands, acc_o next accumulator value, carry_o carry out of ACC_W.
// Config: define SUM_ACC_SAT_EN to saturate instead of wrapping.
module sum_acc_add import sum_acc_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              carry_o
);
    logic [ACC_W:0] sum;

    assign sum     = {1'b0, acc_i} + {{(ACC_W + 1 - DATA_W){1'b0}}, sample_i};
    assign carry_o = sum[ACC_W];

`ifdef SUM_ACC_SAT_EN
    // Once clamped, any further non-zero add carries again, so the block stays pinned.
    assign acc_o = carry_o ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_o = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Sums BLOCK_LEN unsigned samples per block and presents the block sum with a sticky overflow flag.
// Latency: result valid 1 cycle after the last beat of the block is accepted.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
// Ports: clk, rst_n (async active-low), clear (sync abort), bus (slave side of sum_accumulator_if).
// Config: SUM_ACC_SAT_EN (saturating add, handled inside sum_acc_add).
module sum_accumulator import sum_acc_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    sum_accumulator_if.slave   bus
);
    localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic               accept;

    sum_acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_i    (acc_q),
        .sample_i (bus.in_data),
        .acc_o    (add_sum),
        .carry_o  (add_carry)
    );

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        if (clear) begin
            // Abort wins over any beat or result transfer this cycle.
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = {{(ACC_W - DATA_W){1'b0}}, bus.in_data};
                        count_d = 8'd1;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        count_d = count_q + 8'd1;
                        ovf_d   = ovf_q | add_carry;
                        if (count_q == LAST_CNT) begin
                            // Capture the result from the final add so it is stable in HOLD.
                            out_data_d = add_sum;
                            out_ovf_d  = ovf_q | add_carry;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: default-sized instance for block/handshake/clear/reset cases,
// plus a 9-bit accumulator instance for the overflow case.
// Ports: none (top-level bench).
module tb_sum_accumulator;
    import sum_acc_pkg::*;

    logic clk;
    logic rst_n;
    logic clr_a;
    logic clr_b;

    int n_checks;
    int n_errors;

    sum_accumulator_if #(.DATA_W(8), .ACC_W(16)) a_if ();
    sum_accumulator_if #(.DATA_W(8), .ACC_W(9))  b_if ();

    sum_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clr_a),
        .bus   (a_if.slave)
    );

    sum_accumulator #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clr_b),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [7:0] d);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        tick();
        a_if.in_valid = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] d);
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        tick();
        b_if.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready",  32'(a_if.in_ready),  32'd1);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data",  32'(a_if.out_data),  32'd0);
        check("rst_out_ovf",   32'(a_if.out_ovf),   32'd0);
        check("rst_b_valid",   32'(b_if.out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic block, consumer always ready
        beat_a(8'd10);
        beat_a(8'd20);
        beat_a(8'd30);
        check("blk_valid_before_last", 32'(a_if.out_valid), 32'd0);
        beat_a(8'd40);
        check("blk_valid",  32'(a_if.out_valid), 32'd1);
        check("blk_data",   32'(a_if.out_data),  32'd100);
        check("blk_ovf",    32'(a_if.out_ovf),   32'd0);
        check("blk_rdy_hold", 32'(a_if.in_ready), 32'd0);
        tick();
        check("blk_valid_one_cycle", 32'(a_if.out_valid), 32'd0);
        check("blk_data_held_idle",  32'(a_if.out_data),  32'd100);
        check("blk_rdy_idle",        32'(a_if.in_ready),  32'd1);

        // Backpressure: result held for 3 cycles, stray sample during HOLD ignored
        a_if.out_ready = 1'b0;
        beat_a(8'd10);
        beat_a(8'd20);
        beat_a(8'd30);
        beat_a(8'd40);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'd99;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid",    32'(a_if.out_valid), 32'd1);
            check("bp_data",     32'(a_if.out_data),  32'd100);
            check("bp_in_ready", 32'(a_if.in_ready),  32'd0);
            if (i < 2) tick();
        end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        check("bp_done", 32'(a_if.out_valid), 32'd0);

        // Clear aborts a partial block
        beat_a(8'd5);
        beat_a(8'd5);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("clr_valid", 32'(a_if.out_valid), 32'd0);
        beat_a(8'd1);
        beat_a(8'd1);
        beat_a(8'd1);
        beat_a(8'd1);
        check("clr_valid_after", 32'(a_if.out_valid), 32'd1);
        check("clr_data",        32'(a_if.out_data),  32'd4);
        check("clr_ovf",         32'(a_if.out_ovf),   32'd0);
        tick();

        // Clear wins over an in-flight result
        a_if.out_ready = 1'b0;
        beat_a(8'd7);
        beat_a(8'd7);
        beat_a(8'd7);
        beat_a(8'd7);
        check("clr_hold_valid", 32'(a_if.out_valid), 32'd1);
        check("clr_hold_data",  32'(a_if.out_data),  32'd28);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        a_if.out_ready = 1'b1;
        check("clr_hold_dropped", 32'(a_if.out_valid), 32'd0);
        check("clr_hold_rdy",     32'(a_if.in_ready),  32'd1);

        // Asynchronous reset during HOLD
        a_if.out_ready = 1'b0;
        beat_a(8'd2);
        beat_a(8'd2);
        beat_a(8'd2);
        beat_a(8'd2);
        check("arst_pre_data", 32'(a_if.out_data), 32'd8);
        #2;
        rst_n = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'd50;
        #1;
        check("arst_valid", 32'(a_if.out_valid), 32'd0);
        check("arst_data",  32'(a_if.out_data),  32'd0);
        check("arst_rdy",   32'(a_if.in_ready),  32'd1);
        tick();
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        tick();
        beat_a(8'd2);
        beat_a(8'd2);
        beat_a(8'd2);
        beat_a(8'd2);
        check("arst_post_valid", 32'(a_if.out_valid), 32'd1);
        check("arst_post_data",  32'(a_if.out_data),  32'd8);
        tick();

        // in_valid toggling: idle cycles do not advance the block
        for (int i = 0; i < 4; i++) begin
            beat_a(8'd3);
            if (i < 3) begin
                tick();
                check("gap_no_valid", 32'(a_if.out_valid), 32'd0);
            end
        end
        check("gap_valid", 32'(a_if.out_valid), 32'd1);
        check("gap_data",  32'(a_if.out_data),  32'd12);
        tick();

        // 9-bit accumulator overflow
        beat_b(8'd255);
        beat_b(8'd255);
        beat_b(8'd255);
        beat_b(8'd255);
        check("ovf_valid", 32'(b_if.out_valid), 32'd1);
`ifdef SUM_ACC_SAT_EN
        check("ovf_data", 32'(b_if.out_data), 32'd511);
`else
        check("ovf_data", 32'(b_if.out_data), 32'd508);
`endif
        check("ovf_flag", 32'(b_if.out_ovf), 32'd1);
        tick();

        // Overflow flag is per block: a small block afterwards is clean
        beat_b(8'd1);
        beat_b(8'd2);
        beat_b(8'd3);
        beat_b(8'd4);
        check("ovf_next_data", 32'(b_if.out_data), 32'd10);
        check("ovf_next_flag", 32'(b_if.out_ovf),  32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
